// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding requester for the valid/ready peripheral
// bus. It takes one command at a time, drives the bus until the responder
// answers or the wait budget runs out, and then returns a response.
module bus_initiator #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_wrstb,
  input  logic [31:0]       cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              valid,
  input  logic              ready,
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        wrstb,
  output logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  // cnt holds (REQ cycle number - 1), so the last allowed cycle sees TIMEOUT-1
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t             state, state_d;
  logic [7:0]         cnt, cnt_d;
  logic               cmd_ready_d, rsp_valid_d, rsp_err_d, valid_d, busy_d;
  logic [31:0]        rsp_rdata_d, wdata_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [3:0]         wrstb_d;

  // Register state and every output so nothing combinational reaches a port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      valid     <= 1'b0;
      addr      <= '0;
      wrstb     <= '0;
      wdata     <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      valid     <= valid_d;
      addr      <= addr_d;
      wrstb     <= wrstb_d;
      wdata     <= wdata_d;
      busy      <= busy_d;
    end
  end

  // Next-state and next-output decode; everything holds unless a transition fires
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    cmd_ready_d = cmd_ready;
    rsp_valid_d = rsp_valid;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    valid_d     = valid;
    addr_d      = addr;
    wrstb_d     = wrstb;
    wdata_d     = wdata;
    busy_d      = busy;
    case (state)
      IDLE: begin
        // cmd_ready comes up one edge after reset release, then stays up here
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready) begin
          addr_d      = cmd_addr;
          wrstb_d     = cmd_wrstb;
          wdata_d     = cmd_wdata;
          valid_d     = 1'b1;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = REQ;
        end
      end
      REQ: begin
        // ready in the first REQ cycle may be stale from the previous
        // transaction, so it only counts once cnt has moved off zero.
        // Checking ready before the budget makes ready win a collision.
        if ((cnt != 8'd0) && ready) begin
          valid_d     = 1'b0;
          addr_d      = '0;
          wrstb_d     = '0;
          wdata_d     = '0;
          rsp_rdata_d = (wrstb == 4'd0) ? rdata : 32'd0;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else if (cnt == CNT_LAST) begin
          valid_d     = 1'b0;
          addr_d      = '0;
          wrstb_d     = '0;
          wdata_d     = '0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      RSP: begin
        // Bus stays quiet here; late ready from a timed-out responder is dropped
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_rdata_d = 32'd0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Single-outstanding initiator for the SoC's valid/ready peripheral bus, the requesting end of the protocol that peripheral responders (GPIO, timers, UART) implement. It accepts one word-sized command at a time on a command channel and drives `valid`/`addr`/`wrstb`/`wdata` to a responder. It waits for `ready`, captures `rdata`, and returns the result on a response channel. A programmable timeout converts a silent responder into an error response so the command side never hangs.

## Interface
- `ADDR_W`, 4: width of the bus address.
- `TIMEOUT`, 16: number of REQ cycles to wait for `ready` before aborting. Legal range 2..255.
- `clk` in 1: clock; all logic on its rising edge.
- `reset` in 1: reset, asynchronous and active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when high together with `cmd_valid`.
- `cmd_addr` in ADDR_W: target address.
- `cmd_wrstb` in 4: byte write strobes. Nonzero means write, zero means read.
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed when high together with `rsp_valid`.
- `rsp_rdata` out 32: read data. It is 0 for writes and for errors.
- `rsp_err` out 1: the transaction timed out.
- `valid` out 1: bus request.
- `ready` in 1: bus completion from the responder.
- `addr` out ADDR_W: bus address.
- `wrstb` out 4: bus write strobes.
- `wdata` out 32: bus write data.
- `rdata` in 32: bus read data, valid in the cycle `ready` is high.
- `busy` out 1: high in REQ and RSP.

## Operation
- FSM states: IDLE, REQ, RSP. All outputs are registered.
- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid`: latch `cmd_addr`/`cmd_wrstb`/`cmd_wdata` onto `addr`/`wrstb`/`wdata`, set `valid`=1, clear the wait counter, go to REQ.
  - `ready` is ignored in IDLE.
- **REQ**
  - `valid`=1. `addr`/`wrstb`/`wdata` are held stable.
  - `ready` is ignored in the first REQ cycle. This masks a stale `ready` left over from the previous transaction.
  - From the second REQ cycle on, `ready`=1 ends the request:
    - Clear `valid`.
    - Set `rsp_rdata` = `rdata` for a read, or 0 for a write.
    - Set `rsp_err`=0 and `rsp_valid`=1, go to RSP.
  - Otherwise the counter increments each REQ cycle. When it reaches `TIMEOUT` without `ready`:
    - Clear `valid`.
    - Set `rsp_rdata`=0, `rsp_err`=1, `rsp_valid`=1, go to RSP.
  - If `ready` and the timeout occur in the same cycle, `ready` wins and no error is reported.
- **RSP**
  - `rsp_valid`=1 and all bus outputs are held at 0.
  - When `rsp_ready`=1: clear `rsp_valid`, set `cmd_ready`=1, go to IDLE.
  - RSP lasts at least one cycle. This guarantees at least one bus-idle cycle between requests.
- A `ready` arriving after a timeout (in RSP or IDLE) is dropped silently.
- Reset, including mid-REQ:
  - All outputs go to 0 immediately: `valid`, `addr`, `wrstb`, `wdata`, `rsp_valid`, `rsp_rdata`, `rsp_err`, `busy`, `cmd_ready`.
  - State returns to IDLE and any in-flight command is discarded.
  - `cmd_ready` rises on the first clock edge after reset deasserts.

## Timing
- Cycle numbering:
  - Command accepted at edge 0.
  - `valid` is high from edge 0. The responder samples it at edge 1.
  - A 1-cycle responder raises `ready` after edge 1, and it is sampled at edge 2.
  - `rsp_valid` is high after edge 2.
- Minimum command-to-response latency is 2 cycles.
- With `rsp_ready` tied high, RSP lasts exactly 1 cycle. Minimum throughput is one transaction per 4 cycles (IDLE, REQ, REQ, RSP).
- Timeout: with no `ready`, `valid` is high for exactly `TIMEOUT` cycles. `rsp_err` is asserted on the edge that ends the last of those cycles.
- `valid` is never high in the same cycle as `rsp_valid`.

## Test plan
- **Read.** Use a 1-cycle responder model returning `rdata`=0x00000001 at addr 0x8 (`wrstb`=0).
  - Required: `valid` high for 2 cycles with addr=0x8.
  - Required: response with `rsp_rdata`=0x1 and `rsp_err`=0, 2 cycles after acceptance.
- **Write.** Command addr 0x4, `wrstb`=0xF, `wdata`=0x00000200.
  - Required: the bus shows exactly those values while `valid` is high.
  - Required: `rsp_rdata`=0 and `rsp_err`=0.
- **Timeout.** Responder never raises `ready`, `TIMEOUT`=16.
  - Required: `valid` high for exactly 16 cycles, then `rsp_valid`=1 with `rsp_err`=1 and `rsp_rdata`=0.
  - Inject `ready` 3 cycles later. Required: it is ignored and the next transaction is clean.
- **Back-to-back with backpressure.** Issue two reads with `rsp_ready` held low for 5 cycles on the first.
  - Required: `rsp_valid`, `rsp_rdata` and `rsp_err` are stable while stalled, and `cmd_ready`=0.
  - Required: the second command is accepted only after the handshake.
  - Required: with the 1-cycle responder, the second transaction still takes 2 REQ cycles.
- **Ready/timeout collision.** Responder raises `ready` in exactly REQ cycle 16 with `TIMEOUT`=16.
  - Required: `rsp_err`=0 and `rdata` is captured.
- **Reset mid-REQ.** Assert `reset` asynchronously between clock edges during REQ cycle 3.
  - Required: `valid` and `busy` drop to 0 before the next edge.
  - Required: no response is produced.
  - Required: `cmd_ready`=1 on the first edge after release.
